// File: rtl/bcd_pkg.sv
// Shared types and sizing helpers for the binary-to-BCD formatters.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_e;

  // Digits needed for a bits-wide unsigned value; 1233/4096 approximates log10(2).
  function automatic int nibbles_for(input int bits);
    return ((bits * 32'sd1233) >>> 32'sd12) + 32'sd1;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift the serial bit in at the LSB.
module bcd_dabble_step #(
  parameter int NIBBLES = 10
) (
  input  logic [4*NIBBLES-1:0] bcd_i,
  input  logic                 bit_i,
  output logic [4*NIBBLES-1:0] bcd_o
);

  logic [4*NIBBLES-2:0] adj_s;

  function automatic logic [3:0] add3(input logic [3:0] nib);
    if (nib >= 4'd5) begin
      return nib + 4'd3;
    end else begin
      return nib;
    end
  endfunction

  // Top digit never overflows its 3 low bits into a lost carry, so only those are kept.
  always_comb begin
    adj_s = '0;
    for (int i = 0; i < NIBBLES - 1; i++) begin
      adj_s[4*i +: 4] = add3(bcd_i[4*i +: 4]);
    end
    adj_s[4*(NIBBLES-1) +: 3] = 3'(add3(bcd_i[4*(NIBBLES-1) +: 4]));
  end

  assign bcd_o = {adj_s, bit_i};

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one shared dabble stage, BITS shift cycles per operand,
// valid/ready on input and output, optional two's-complement input.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BITS   = 32,
  parameter bit SIGNED = 1'b0,
  localparam int NIBBLES = nibbles_for(BITS),
  localparam int NDW     = $clog2(NIBBLES + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [BITS-1:0]      in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [4*NIBBLES-1:0] out_bcd_o,
  output logic                 out_neg_o,
  output logic [NDW-1:0]       out_ndigits_o
);

  localparam int CW = $clog2(BITS);

  bcd_state_e           state_q;
  logic [BITS-1:0]      mag_q;
  logic [4*NIBBLES-1:0] bcd_q;
  logic [4*NIBBLES-1:0] bcd_d;
  logic                 neg_q;
  logic [CW-1:0]        cnt_q;
  logic                 in_ready_q;
  logic                 out_valid_q;

  logic                 neg_s;
  logic [BITS-1:0]      mag_s;
  logic [NDW-1:0]       nd_s;

  bcd_dabble_step #(.NIBBLES(NIBBLES)) u_step (
    .bcd_i (bcd_q),
    .bit_i (mag_q[BITS-1]),
    .bcd_o (bcd_d)
  );

  // Magnitude of the incoming operand; the most negative value maps to 2^(BITS-1) by wrap.
  always_comb begin
    neg_s = SIGNED && in_data_i[BITS-1];
    if (neg_s) begin
      mag_s = ~in_data_i + BITS'(1);
    end else begin
      mag_s = in_data_i;
    end
  end

  // Significant-digit count from the accumulator; a zero result still reports one digit.
  always_comb begin
    nd_s = NDW'(1);
    for (int i = 0; i < NIBBLES; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) begin
        nd_s = NDW'(i + 1);
      end else begin
        nd_s = nd_s;
      end
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      bcd_q       <= '0;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i && in_ready_q) begin
            mag_q      <= mag_s;
            neg_q      <= neg_s;
            bcd_q      <= '0;
            cnt_q      <= CW'(BITS - 1);
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= bcd_d;
          mag_q <= {mag_q[BITS-2:0], 1'b0};
          if (cnt_q == CW'(0)) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready_o    = in_ready_q;
  assign out_valid_o   = out_valid_q;
  assign out_bcd_o     = bcd_q;
  assign out_neg_o     = neg_q;
  assign out_ndigits_o = nd_s;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and randomized checks of bin2bcd_seq across several BITS/SIGNED configurations.
module tb_bin2bcd_seq;
  import bcd_pkg::*;

  localparam int NI = 11;
  localparam int BW [NI] = '{32, 8, 8, 16, 4, 13, 64, 4, 13, 64, 32};
  localparam bit SG [NI] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  logic        clk = 1'b0;
  logic        rst;
  logic        ordy;
  logic [63:0] din;
  logic        ival   [NI];
  logic        irdy   [NI];
  logic        ovalid [NI];
  logic        oneg   [NI];
  logic [79:0] obcd   [NI];
  logic [7:0]  ond    [NI];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int NB = nibbles_for(BW[k]);
    logic [4*NB-1:0]          bcd_l;
    logic [$clog2(NB+1)-1:0]  nd_l;
    bin2bcd_seq #(.BITS(BW[k]), .SIGNED(SG[k])) u_dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .in_valid_i    (ival[k]),
      .in_ready_o    (irdy[k]),
      .in_data_i     (din[BW[k]-1:0]),
      .out_valid_o   (ovalid[k]),
      .out_ready_i   (ordy),
      .out_bcd_o     (bcd_l),
      .out_neg_o     (oneg[k]),
      .out_ndigits_o (nd_l)
    );
    assign obcd[k] = 80'(bcd_l);
    assign ond[k]  = 8'(nd_l);
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decimal conversion by repeated division.
  function automatic logic [79:0] ref_bcd(input logic [63:0] m);
    logic [79:0] r;
    logic [63:0] v;
    r = '0;
    v = m;
    for (int i = 0; i < 20; i++) begin
      r[4*i +: 4] = 4'(v % 64'd10);
      v = v / 64'd10;
    end
    return r;
  endfunction

  function automatic logic [63:0] mask_of(input int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] mag_of(input int w, input bit s, input logic [63:0] v);
    logic [63:0] x;
    x = v & mask_of(w);
    if (s && x[w-1]) return (~x + 64'd1) & mask_of(w);
    return x;
  endfunction

  function automatic int ndig(input logic [79:0] b);
    int n;
    n = 1;
    for (int i = 0; i < 20; i++) if (b[4*i +: 4] != 4'd0) n = i + 1;
    return n;
  endfunction

  // One full transaction on instance k with expected result and optional disturbances.
  task automatic run(input int k, input logic [63:0] data, input logic [79:0] eb, input logic en,
                     input int end_nd, input int hold, input bit noise, input bit rnd_rdy);
    int n;
    @(negedge clk);
    check("in_ready_idle", irdy[k], 1);
    din     = data;
    ival[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ival[k] = noise;
    if (noise) din = ~data;
    check("in_ready_shift", irdy[k], 0);
    n = 0;
    while (ovalid[k] !== 1'b1 && n < 200) begin
      if (rnd_rdy) ordy = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    ordy = 1'b0;
    check("latency", n, BW[k]);
    check("bcd", obcd[k], eb);
    check("neg", oneg[k], en);
    check("ndigits", ond[k], end_nd);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", ovalid[k], 1);
      check("hold_bcd", obcd[k], eb);
      check("hold_in_ready", irdy[k], 0);
    end
    ordy = 1'b1;
    @(negedge clk);
    ordy    = 1'b0;
    ival[k] = 1'b0;
    check("post_valid", ovalid[k], 0);
    check("post_in_ready", irdy[k], 1);
  endtask

  initial begin
    int          seen;
    int          k;
    logic [63:0] data;
    logic [79:0] eb;

    rst  = 1'b1;
    ordy = 1'b0;
    din  = 64'd0;
    foreach (ival[i]) ival[i] = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", ovalid[0], 0);
    check("rst_bcd", obcd[0], 0);
    check("rst_neg", oneg[1], 0);
    check("rst_ndigits", ond[0], 1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", irdy[0], 1);

    run(0, 64'd0, 80'h0, 1'b0, 1, 0, 1'b0, 1'b0);
    run(0, 64'd4294967295, 80'h4294967295, 1'b0, 10, 0, 1'b0, 1'b0);
    run(1, 64'h80, 80'h128, 1'b1, 3, 0, 1'b0, 1'b0);
    run(1, 64'hFF, 80'h001, 1'b1, 1, 0, 1'b0, 1'b0);
    run(1, 64'h7F, 80'h127, 1'b0, 3, 0, 1'b1, 1'b0);
    run(2, 64'd255, 80'h255, 1'b0, 3, 10, 1'b0, 1'b0);

    // Abort a 16-bit conversion with a one-cycle reset mid-shift.
    @(negedge clk);
    din     = 64'd999;
    ival[3] = 1'b1;
    @(negedge clk);
    ival[3] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_rst_valid", ovalid[3], 0);
    check("abort_rst_bcd", obcd[3], 0);
    check("abort_rst_ndigits", ond[3], 1);
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", irdy[3], 1);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (ovalid[3] !== 1'b0) seen = 1;
    end
    check("abort_no_valid", seen, 0);
    run(3, 64'd1234, 80'h01234, 1'b0, 4, 0, 1'b0, 1'b0);

    // Randomized sweep over the {4,13,32,64} x {unsigned,signed} instances.
    for (int it = 0; it < 40; it++) begin
      k    = $urandom_range(0, 7);
      k    = (k == 0) ? 0 : k + 3;
      data = {$urandom, $urandom};
      if (it < 8) data = (it[0]) ? 64'd0 : 64'hFFFF_FFFF_FFFF_FFFF;
      eb   = ref_bcd(mag_of(BW[k], SG[k], data));
      run(k, data, eb, SG[k] && data[BW[k]-1], ndig(eb), $urandom_range(0, 3), 1'b1, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential, parametrised binary-to-BCD converter; successor to the team's combinational double-dabble block. It converts one operand at a time over BITS clock cycles using a single shared shift/add-3 stage instead of an unrolled array. It handles the full unsigned range of any width, has an optional two's-complement signed mode, and reports the significant-digit count. It sits between arithmetic datapaths and the display/UART formatting logic, with valid/ready handshakes on both sides.

## Interface
- BITS, 32, input operand width; legal range 4..64.
- SIGNED, 0, 1 = in_data is two's complement, 0 = unsigned.
- NIBBLES, derived, ((BITS*1233)>>12)+1; number of BCD digits; not to be overridden.
- clk  input  1  single clock; everything is rising-edge.
- rst  input  1  reset is synchronous and active-high.
- in_valid  input  1  operand present.
- in_ready  output  1  block can accept an operand (IDLE only).
- in_data  input  BITS  operand.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_bcd  output  4*NIBBLES  packed BCD magnitude; digit 0 in [3:0].
- out_neg  output  1  result is negative (SIGNED=1 only; tied 0 otherwise).
- out_ndigits  output  $clog2(NIBBLES+1)  index of highest non-zero digit +1; minimum 1.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. When in_valid && in_ready:
  - load the shift register with the magnitude;
  - set neg_q = SIGNED && in_data[BITS-1];
  - clear the BCD accumulator;
  - set bit counter = BITS-1;
  - go to SHIFT.
- Magnitude: if neg, -in_data computed as a BITS-bit unsigned value, so -2^(BITS-1) yields 2^(BITS-1). Otherwise in_data.
- SHIFT, one step per cycle:
  - every nibble >= 5 gets +3 (4-bit wrap impossible by construction);
  - then {bcd, mag} shifts left by 1, so the mag MSB enters bcd[0];
  - when the counter reaches 0 (after BITS steps), go to DONE; otherwise decrement.
- DONE:
  - out_valid=1; out_bcd, out_neg and out_ndigits are held stable;
  - on out_valid && out_ready, go to IDLE.
- in_ready=0 in SHIFT and DONE. in_data and in_valid are ignored there; no queuing.
- out_ndigits is combinational from the registered accumulator. A zero result gives out_bcd=0, out_ndigits=1, out_neg=0.
- Zero is never negative; this holds by construction, since -0 = 0 and neg_q only comes from the sign bit.

## Timing
- Reset (synchronous): state=IDLE, accumulator=0, neg_q=0, counter=0.
  - During the rst cycle: out_valid=0, out_bcd=0, out_neg=0, out_ndigits=1.
  - in_ready is 1 from the first cycle after rst deasserts.
- Reset asserted in SHIFT or DONE aborts the conversion. The result is discarded, with no out_valid pulse.
- Latency: for an accept on edge E, out_valid is first high after edge E+BITS.
- In DONE, out_valid holds with stable data until out_ready is sampled high. A handshake on edge F returns to IDLE, with in_ready=1 after F.
- Minimum initiation interval: BITS+2 cycles (accept, BITS shifts, DONE handshake).
- out_ready is ignored outside DONE. An out_ready held constantly high still gives exactly one transfer per conversion.

## Structure
- Package bcd_pkg holds:
  - the state enum (IDLE/SHIFT/DONE);
  - a constant function nibbles_for(bits) implementing ((bits*1233)>>12)+1, shared with other formatters.
- One sub-module: bcd_dabble_step.
  - Combinational, parameter NIBBLES.
  - Inputs: bcd vector and serial bit. Output: adjusted-and-shifted bcd vector.
  - It is instantiated once in the FSM datapath and is reusable for an unrolled variant.
- Expected RTL: top ~150 lines, step ~40 lines, package ~20 lines.

## Test plan
- BITS=32, SIGNED=0, in_data=0 -> out_bcd=0, out_ndigits=1, out_valid rises exactly 32 cycles after the accept edge.
- BITS=32, SIGNED=0, in_data=4294967295 -> out_bcd=0x4294967295 (40 bits), out_ndigits=10, out_neg=0.
- BITS=8, SIGNED=1:
  - in_data=0x80 -> out_bcd=0x128, out_neg=1, out_ndigits=3;
  - in_data=0xFF -> 0x001, neg=1, ndigits=1;
  - in_data=0x7F -> 0x127, neg=0.
- BITS=8, SIGNED=0, in_data=255, out_ready held low 10 cycles after out_valid -> output stable throughout, in_ready=0. When out_ready rises: one transfer, in_ready=1 the next cycle.
- rst pulsed for one cycle mid-SHIFT -> out_valid never asserts for the aborted operand. The next operand 1234 (BITS=16) yields 0x01234, ndigits=4, with normal latency.
- Random sweep, BITS in {4,13,32,64} with both SIGNED values, plus randomized out_ready backpressure -> every out_bcd matches a reference decimal conversion, and in_valid asserted during SHIFT/DONE is never accepted.
